// File: rtl/regfile_op_sequencer.sv
// Execute/writeback sequencer for the 8x8 2R1W register file: READ -> EXEC -> WRITE per instruction.
// Optional STATUS_FLAGS_EN adds registered zero_flag/carry_flag outputs updated in EXEC.
module regfile_op_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [2:0]            instr_op,
  input  logic [ADDR_WIDTH-1:0] instr_rd,
  input  logic [ADDR_WIDTH-1:0] instr_rs1,
  input  logic [ADDR_WIDTH-1:0] instr_rs2,
  output logic [ADDR_WIDTH-1:0] read_address_1,
  output logic [ADDR_WIDTH-1:0] read_address_2,
  output logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] read_data_1,
  input  logic [DATA_WIDTH-1:0] read_data_2,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_enable,
  output logic                  done,
  output logic                  busy
`ifdef STATUS_FLAGS_EN
  ,
  output logic                  zero_flag,
  output logic                  carry_flag
`endif
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_MOV = 3'b101, OP_NOT = 3'b110, OP_SHL = 3'b111
  } op_e;

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d, wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  ready_q, ready_d, busy_q, busy_d, ren_q, ren_d, wen_q, wen_d;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_carry;
  logic [DATA_WIDTH:0]   sum_ext;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    sum_ext   = {1'b0, read_data_1} + {1'b0, read_data_2};
    unique case (op_q)
      OP_ADD: begin alu_res = sum_ext[DATA_WIDTH-1:0]; alu_carry = sum_ext[DATA_WIDTH]; end
      OP_SUB: begin alu_res = read_data_1 - read_data_2; alu_carry = (read_data_1 < read_data_2); end
      OP_AND: alu_res = read_data_1 & read_data_2;
      OP_OR:  alu_res = read_data_1 | read_data_2;
      OP_XOR: alu_res = read_data_1 ^ read_data_2;
      OP_MOV: alu_res = read_data_1;
      OP_NOT: alu_res = ~read_data_1;
      OP_SHL: begin alu_res = {read_data_1[DATA_WIDTH-2:0], 1'b0}; alu_carry = read_data_1[DATA_WIDTH-1]; end
      default: alu_res = '0;
    endcase
  end

`ifdef STATUS_FLAGS_EN
  logic zero_q, zero_d, carry_q, carry_d;
  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    wr_addr_d = wr_addr_q;
    result_d  = result_q;
`ifdef STATUS_FLAGS_EN
    zero_d    = zero_q;
    carry_d   = carry_q;
`endif
    unique case (state_q)
      IDLE: if (instr_valid && ready_q) begin
        op_d    = op_e'(instr_op);
        rd_d    = instr_rd;
        rs1_d   = instr_rs1;
        rs2_d   = instr_rs2;
        state_d = READ;
      end
      READ: state_d = EXEC;
      EXEC: begin
        // Operands sampled at the end of EXEC so a registered-read file also works.
        result_d  = alu_res;
        wr_addr_d = rd_q;
`ifdef STATUS_FLAGS_EN
        zero_d    = (alu_res == '0);
        carry_d   = alu_carry;
`endif
        state_d   = WRITE;
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Handshake/enable outputs are registered from the next state.
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    ren_d   = (state_d == READ) || (state_d == EXEC);
    wen_d   = (state_d == WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      wr_addr_q <= '0;
      result_q  <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
`ifdef STATUS_FLAGS_EN
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      wr_addr_q <= wr_addr_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
`ifdef STATUS_FLAGS_EN
      zero_q    <= zero_d;
      carry_q   <= carry_d;
`endif
    end
  end

  assign instr_ready    = ready_q;
  assign busy           = busy_q;
  assign read_enable    = ren_q;
  assign write_enable   = wen_q;
  assign done           = wen_q;
  assign read_address_1 = rs1_q;
  assign read_address_2 = rs2_q;
  assign write_address  = wr_addr_q;
  assign write_data     = result_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer: register-file model, vector table, scoreboard of expected writebacks.
module tb_regfile_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op = '0, instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic [2:0] read_address_1, read_address_2, write_address;
  logic       read_enable, write_enable, done, busy;
  logic [7:0] read_data_1, read_data_2, write_data;
`ifdef STATUS_FLAGS_EN
  logic       zero_flag, carry_flag;
`endif

  regfile_op_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .read_address_1(read_address_1), .read_address_2(read_address_2), .read_enable(read_enable),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .write_address(write_address), .write_data(write_data), .write_enable(write_enable),
    .done(done), .busy(busy)
`ifdef STATUS_FLAGS_EN
    , .zero_flag(zero_flag), .carry_flag(carry_flag)
`endif
  );

  always #5 clk = ~clk;

  // Register file model: combinational read, write on the rising edge; preload port for the bench.
  logic [7:0] rf [8];
  logic       pl_we = 1'b0;
  logic [2:0] pl_a = '0;
  logic [7:0] pl_d = '0;
  assign read_data_1 = rf[read_address_1];
  assign read_data_2 = rf[read_address_2];
  always @(posedge clk) begin
    if (write_enable) rf[write_address] <= write_data;
    else if (pl_we)   rf[pl_a] <= pl_d;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] op, rd, rs1, rs2;
    logic [7:0] a, b, exp;
    logic       c;
  } vec_t;
  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    logic       c;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] gold [8];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [8:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; alu = s; end
      3'd1: alu = {(a < b), 8'(a - b)};
      3'd2: alu = {1'b0, a & b};
      3'd3: alu = {1'b0, a | b};
      3'd4: alu = {1'b0, a ^ b};
      3'd5: alu = {1'b0, a};
      3'd6: alu = {1'b0, ~a};
      default: alu = {a[7], a[6:0], 1'b0};
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (read_enable && write_enable) check("rd_wr_overlap", 1, 0);
      if (write_enable) begin
        if (sb.size() == 0) check("unexpected_write", 1, 0);
        else begin
          mon_e = sb.pop_front();
          check("wr_addr", write_address, mon_e.addr);
          check("wr_data", write_data, mon_e.data);
          check("done", done, 1);
`ifdef STATUS_FLAGS_EN
          check("carry_flag", carry_flag, mon_e.c);
          check("zero_flag", zero_flag, mon_e.data == 8'h00);
`endif
        end
      end
    end
  end

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk);
    #1 pl_we = 1'b0;
    gold[a] = d;
  endtask

  // Leaves instr_valid high after acceptance; caller drops it.
  task automatic issue(input logic [2:0] op, rd, rs1, rs2, input logic [7:0] exp, input logic c,
                       output int unsigned acc);
    int unsigned cnt = 0;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    while (!instr_ready && cnt < 40) begin @(negedge clk); cnt++; end
    acc = 0;
    if (!instr_ready) begin
      check("accept_timeout", 0, 1);
      instr_valid = 1'b0;
    end else begin
      @(posedge clk);
      sb.push_back('{rd, exp, c});
      gold[rd] = exp;
      #1 acc = cyc;
    end
  endtask

  task automatic issue_model(input logic [2:0] op, rd, rs1, rs2, output int unsigned acc);
    logic [8:0] r;
    r = alu(op, gold[rs1], gold[rs2]);
    issue(op, rd, rs1, rs2, r[7:0], r[8], acc);
  endtask

  task automatic drain();
    int unsigned cnt = 0;
    instr_valid = 1'b0;
    while ((sb.size() != 0 || !instr_ready) && cnt < 40) begin @(negedge clk); cnt++; end
    if (sb.size() != 0 || !instr_ready) check("drain_timeout", 0, 1);
  endtask

  vec_t        tbl [13];
  int unsigned a1, a2;
  logic [7:0]  pre;

  initial begin
    tbl[0]  = '{3'd0, 3'd3, 3'd1, 3'd2, 8'h0F, 8'h01, 8'h10, 1'b0};
    tbl[1]  = '{3'd0, 3'd4, 3'd5, 3'd6, 8'hF0, 8'h20, 8'h10, 1'b1};
    tbl[2]  = '{3'd1, 3'd1, 3'd1, 3'd2, 8'h00, 8'h01, 8'hFF, 1'b1};
    tbl[3]  = '{3'd1, 3'd0, 3'd3, 3'd4, 8'h05, 8'h05, 8'h00, 1'b0};
    tbl[4]  = '{3'd2, 3'd7, 3'd0, 3'd1, 8'hCC, 8'hAA, 8'h88, 1'b0};
    tbl[5]  = '{3'd3, 3'd2, 3'd0, 3'd1, 8'hCC, 8'hAA, 8'hEE, 1'b0};
    tbl[6]  = '{3'd4, 3'd5, 3'd0, 3'd1, 8'hCC, 8'hAA, 8'h66, 1'b0};
    tbl[7]  = '{3'd5, 3'd6, 3'd2, 3'd3, 8'h5A, 8'h11, 8'h5A, 1'b0};
    tbl[8]  = '{3'd6, 3'd2, 3'd2, 3'd3, 8'h5A, 8'h11, 8'hA5, 1'b0};
    tbl[9]  = '{3'd7, 3'd0, 3'd7, 3'd6, 8'h81, 8'h00, 8'h02, 1'b1};
    tbl[10] = '{3'd7, 3'd1, 3'd7, 3'd6, 8'h40, 8'h00, 8'h80, 1'b0};
    tbl[11] = '{3'd0, 3'd3, 3'd4, 3'd5, 8'hFF, 8'h01, 8'h00, 1'b1};
    tbl[12] = '{3'd1, 3'd6, 3'd6, 3'd7, 8'h10, 8'h20, 8'hF0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_re", read_enable, 0);
    check("rst_we", write_enable, 0);
    check("rst_done", done, 0);
    check("rst_ra1", read_address_1, 0);
    check("rst_wa", write_address, 0);
    check("rst_wd", write_data, 0);
    @(negedge clk) rst_n = 1'b1;

    // ADD cycle-by-cycle timing
    preload(3'd1, 8'h0F);
    preload(3'd2, 8'h01);
    issue(3'd0, 3'd3, 3'd1, 3'd2, 8'h10, 1'b0, a1);
    instr_valid = 1'b0;
    check("c1_re", read_enable, 1);
    check("c1_ra", {read_address_1, read_address_2}, {3'd1, 3'd2});
    check("c1_ready", instr_ready, 0);
    check("c1_busy", busy, 1);
    @(posedge clk); #1;
    check("c2_re", read_enable, 1);
    check("c2_ra", {read_address_1, read_address_2}, {3'd1, 3'd2});
    @(posedge clk); #1;
    check("c3_we", {write_enable, done, read_enable}, 3'b110);
    check("c3_wa_wd", {write_address, write_data}, {3'd3, 8'h10});
    @(posedge clk); #1;
    check("c4_ready", {instr_ready, busy, write_enable}, 3'b100);
    drain();

    for (int i = 0; i < 13; i++) begin
      preload(tbl[i].rs1, tbl[i].a);
      preload(tbl[i].rs2, tbl[i].b);
      issue(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].exp, tbl[i].c, a1);
      drain();
    end

    // Back-to-back with dependency, valid held high throughout
    preload(3'd5, 8'h3C);
    issue_model(3'd4, 3'd4, 3'd5, 3'd5, a1);
    issue_model(3'd5, 3'd6, 3'd4, 3'd0, a2);
    check("b2b_spacing", a2 - a1, 4);
    drain();
    check("b2b_rf6", rf[6], 8'h00);

    // Stall: SHL presented while busy
    preload(3'd7, 8'h81);
    issue_model(3'd0, 3'd0, 3'd1, 3'd2, a1);
    @(negedge clk);
    instr_op = 3'd7; instr_rd = 3'd5; instr_rs1 = 3'd7; instr_rs2 = 3'd0;
    check("stall_ready", instr_ready, 0);
    issue(3'd7, 3'd5, 3'd7, 3'd0, 8'h02, 1'b1, a2);
    check("stall_spacing", a2 - a1, 4);
    drain();

    // Reset during EXEC aborts without a write
    pre = rf[3];
    issue_model(3'd0, 3'd3, 3'd1, 3'd2, a1);
    instr_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_outputs", {read_enable, write_enable, done, busy, read_address_1, write_data}, '0);
    check("abort_ready", instr_ready, 1);
    sb.delete();
    gold[3] = pre;
    repeat (3) @(posedge clk);
    check("abort_no_write", rf[3], pre);
    @(negedge clk) rst_n = 1'b1;
    #1 check("post_rst_ready", instr_ready, 1);
    preload(3'd1, 8'h22);
    preload(3'd2, 8'h33);
    issue(3'd0, 3'd3, 3'd1, 3'd2, 8'h55, 1'b0, a1);
    drain();
    check("post_rst_rf3", rf[3], 8'h55);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
